mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the MIPS datapath (IF, register-file/decode, ALU, data memory).
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath write-enable and mux select, and handshakes with memory via mem_ready.
- Replaces per-stage free-running clocking with explicit per-state enables.

Parameters:
TIMEOUT, 15, max cycles to wait for mem_ready before retrying an access (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-low reset
enable  in  1  0 = freeze FSM, counters and all strobes
opcode  in  6  Instruction[31:26] from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
pc_we  out  1  PC write
pc_src  out  2  00 ALU result, 01 branch target, 10 jump target
ir_we  out  1  instruction register write
iord  out  1  0 = PC address, 1 = ALU-out address
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
rf_we  out  1  register file write
reg_dst  out  1  1 = Rd, 0 = Rt
mem_to_reg  out  1  1 = MDR, 0 = ALU-out
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
mem_err  out  1  one-cycle pulse on access timeout
state  out  4  current state, for debug
instr_cnt  out  CNT_W  retired instruction count

Behaviour:
- Reset (rst==0 at posedge) → state=FETCH, wait_cnt=0, instr_cnt=0, mem_err=0. Reset has priority over enable and aborts any in-flight access.
- All outputs default 0 in every state. Strobes are decoded from state, with mem_ready qualification where noted.
- States (4-bit encoding) and actions:
  - FETCH(0): mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. On mem_ready: ir_we=1, pc_we=1, pc_src=00, next DECODE. Otherwise stay.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
    - 000000 → REXEC
    - 100011 (lw), 101011 (sw), 001000 (addi) → MEMADR
    - 000100 (beq) → BRANCH
    - 000010 (j) → JUMP
    - any other opcode → illegal-opcode handling (see Optional Feature).
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw → MEMRD, sw → MEMWR, addi → ADDIWB.
  - MEMRD(3): mem_rd=1, iord=1. On mem_ready → MEMWB.
  - MEMWB(4): rf_we=1, reg_dst=0, mem_to_reg=1. Next FETCH; retires.
  - MEMWR(5): mem_wr=1, iord=1. On mem_ready → FETCH; retires.
  - REXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Next ALUWB.
  - ALUWB(7): rf_we=1, reg_dst=1, mem_to_reg=0. Next FETCH; retires.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_we=zero. Next FETCH; retires.
  - JUMP(9): pc_src=10, pc_we=1. Next FETCH; retires.
  - ADDIWB(10): rf_we=1, reg_dst=0, mem_to_reg=0. Next FETCH; retires.
  - TRAP(11): see Optional Feature.
- opcode is sampled only in DECODE and MEMADR.
- Retire: instr_cnt increments by 1 on the cycle the FSM leaves a retiring state; wraps modulo 2^CNT_W.
- Latencies with mem_ready held high:
  - R-type and addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq and j: 3 cycles
- Memory wait states (FETCH, MEMRD, MEMWR):
  - wait_cnt (8-bit) increments each enabled cycle that mem_ready==0.
  - When wait_cnt reaches TIMEOUT with mem_ready still 0: mem_err=1 for that cycle, wait_cnt←0, state unchanged (access retried; strobe stays high).
  - mem_ready==1 clears wait_cnt. mem_ready on the timeout cycle completes the access with no mem_err.
- enable==0:
  - state, wait_cnt and instr_cnt hold.
  - pc_we, ir_we, rf_we, mem_rd, mem_wr and mem_err are forced 0.
  - mem_ready is ignored.
  - Mux selects still reflect state.

Optional Feature:
- Macro MC_CTRL_TRAP_EN.
- Defined:
  - An illegal opcode in DECODE → TRAP.
  - TRAP holds all strobes 0 and does not increment instr_cnt.
  - TRAP is exited only by reset.
  - Port trap (out, 1) is 1 while in TRAP, reset value 0.
- Undefined:
  - An illegal opcode is a NOP: DECODE → FETCH, retires (instr_cnt increments).
  - No trap port; TRAP encoding is unreachable.

Test Plan:
- Reset, then mem_ready=1, opcode=000000 → states 0,1,6,7,0. ir_we/pc_we high in cycle 1, rf_we=1 with reg_dst=1 in cycle 4, instr_cnt=1.
- lw (100011) with mem_ready low 3 cycles in MEMRD → mem_rd and iord held; MEMWB entered the cycle after mem_ready; rf_we=1, mem_to_reg=1; total 8 cycles.
- beq with zero=1 then zero=0 → pc_we=1 with pc_src=01 in BRANCH for the first, pc_we=0 for the second; instr_cnt=2.
- TIMEOUT=3 and mem_ready=0 in FETCH → mem_err pulses on cycles 4 and 8, mem_rd stays 1, no state change.
- enable dropped for 5 cycles in MEMWR → state 5 held, mem_wr=0 throughout; after re-enable and mem_ready, FETCH next.
- opcode=111111: with MC_CTRL_TRAP_EN → state 11, trap=1, cleared only by rst=0. Without it → FETCH after DECODE, instr_cnt+1.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute/memory/writeback with
// memory handshake, access timeout retry and retired-instruction counter.
// Optional macro MC_CTRL_TRAP_EN: illegal opcodes lock the FSM in TRAP until reset.
module mc_ctrl_fsm #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             ir_we,
    output logic             iord,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             rf_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             mem_err,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
`ifdef MC_CTRL_TRAP_EN
    ,
    output logic             trap
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIWB = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       pc_we_s, ir_we_s, mem_rd_s, mem_wr_s, rf_we_s, err_s;
    logic       access_s, retire_s;
    logic [1:0] pc_src_s, alu_src_b_s, alu_op_s;
    logic       iord_s, reg_dst_s, mem_to_reg_s, alu_src_a_s;

    // Next-state, wait-counter and strobe decode from the registered state.
    always_comb begin
        state_d      = state_q;
        wait_d       = 8'd0;
        cnt_d        = cnt_q;
        pc_we_s      = 1'b0;
        pc_src_s     = 2'b00;
        ir_we_s      = 1'b0;
        iord_s       = 1'b0;
        mem_rd_s     = 1'b0;
        mem_wr_s     = 1'b0;
        rf_we_s      = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        err_s        = 1'b0;
        access_s     = 1'b0;
        retire_s     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_rd_s    = 1'b1;
                alu_src_b_s = 2'b01;
                access_s    = 1'b1;
                if (mem_ready) begin
                    ir_we_s = 1'b1;
                    pc_we_s = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b_s = 2'b11;
                case (opcode)
                    OP_RTYPE: state_d = S_REXEC;
                    OP_LW:    state_d = S_MEMADR;
                    OP_SW:    state_d = S_MEMADR;
                    OP_ADDI:  state_d = S_MEMADR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    default: begin
`ifdef MC_CTRL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d  = S_FETCH;
                        retire_s = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                case (opcode)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    OP_ADDI: state_d = S_ADDIWB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                mem_rd_s = 1'b1;
                iord_s   = 1'b1;
                access_s = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                rf_we_s      = 1'b1;
                mem_to_reg_s = 1'b1;
                state_d      = S_FETCH;
                retire_s     = 1'b1;
            end
            S_MEMWR: begin
                mem_wr_s = 1'b1;
                iord_s   = 1'b1;
                access_s = 1'b1;
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_REXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we_s   = 1'b1;
                reg_dst_s = 1'b1;
                state_d   = S_FETCH;
                retire_s  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b01;
                pc_src_s    = 2'b01;
                pc_we_s     = zero;
                state_d     = S_FETCH;
                retire_s    = 1'b1;
            end
            S_JUMP: begin
                pc_src_s = 2'b10;
                pc_we_s  = 1'b1;
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_ADDIWB: begin
                rf_we_s  = 1'b1;
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_TRAP: begin
`ifdef MC_CTRL_TRAP_EN
                state_d = S_TRAP;
`else
                state_d = S_FETCH;
`endif
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A timed-out access is retried in place: state and strobe stay put.
        if (access_s) begin
            if (mem_ready) begin
                wait_d = 8'd0;
            end else if (wait_q == TIMEOUT_C) begin
                err_s  = 1'b1;
                wait_d = 8'd0;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end else begin
            wait_d = 8'd0;
        end

        if (retire_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, wait counter and retire counter; reset wins over enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            cnt_q   <= '0;
        end else if (enable) begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end else begin
            state_q <= state_q;
            wait_q  <= wait_q;
            cnt_q   <= cnt_q;
        end
    end

    // Write/access strobes are suppressed while frozen; mux selects still follow state.
    assign pc_we      = enable & pc_we_s;
    assign ir_we      = enable & ir_we_s;
    assign mem_rd     = enable & mem_rd_s;
    assign mem_wr     = enable & mem_wr_s;
    assign rf_we      = enable & rf_we_s;
    assign mem_err    = enable & err_s;
    assign pc_src     = pc_src_s;
    assign iord       = iord_s;
    assign reg_dst    = reg_dst_s;
    assign mem_to_reg = mem_to_reg_s;
    assign alu_src_a  = alu_src_a_s;
    assign alu_src_b  = alu_src_b_s;
    assign alu_op     = alu_op_s;
    assign state      = state_q;
    assign instr_cnt  = cnt_q;
`ifdef MC_CTRL_TRAP_EN
    assign trap       = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Table-driven bench for mc_ctrl_fsm: per-cycle vectors of inputs and expected
// outputs, with expectations queued at drive time and compared mid-cycle.
module tb_mc_ctrl_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, enable, zero, mem_ready;
    logic [5:0]    opcode;
    logic          pc_we, ir_we, iord, mem_rd, mem_wr, rf_we, reg_dst, mem_to_reg;
    logic          alu_src_a, mem_err;
    logic [1:0]    pc_src, alu_src_b, alu_op;
    logic [3:0]    state;
    logic [CW-1:0] instr_cnt;
    logic          trap_w;

    mc_ctrl_fsm #(.TIMEOUT(3), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
        .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .rf_we(rf_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_err(mem_err),
        .state(state), .instr_cnt(instr_cnt)
`ifdef MC_CTRL_TRAP_EN
        , .trap(trap_w)
`endif
    );
`ifndef MC_CTRL_TRAP_EN
    assign trap_w = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          en;
        logic [5:0]    op;
        logic          zr;
        logic          rdy;
        logic [3:0]    st;
        logic [15:0]   ctl;
        logic [CW-1:0] cnt;
        logic          trp;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec_idx = 0;

    logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    logic [5:0] OP_AI = 6'b001000, OP_BQ = 6'b000100, OP_J = 6'b000010, OP_BAD = 6'b111111;
    logic [15:0] F_WAIT, F_RDY, F_ERR, F_OFF, DEC, MADR, MRD, MWB, MWR, MWR_OFF;
    logic [15:0] REX, AWB, BR1, BR0, JMP, AIWB, TRP;

    function automatic logic [15:0] ctl(input logic pcw, input logic [1:0] pcs, input logic irw,
        input logic io, input logic mrd, input logic mwr, input logic rfw, input logic rdst,
        input logic m2r, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
        input logic err);
        return {pcw, pcs, irw, io, mrd, mwr, rfw, rdst, m2r, asa, asb, aop, err};
    endfunction

    function automatic vec_t mk(input logic rn, input logic en, input logic [5:0] op,
        input logic zr, input logic rdy, input logic [3:0] st, input logic [15:0] c,
        input int cnt, input logic trp);
        vec_t v;
        v.rst_n = rn; v.en = en; v.op = op; v.zr = zr; v.rdy = rdy;
        v.st = st; v.ctl = c; v.cnt = CW'(cnt); v.trp = trp;
        return v;
    endfunction

    task automatic check_out();
        vec_t e;
        logic [15:0] act;
        act = {pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, rf_we, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, mem_err};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty vec %0d: got no expectation, required one", vec_idx);
        end else begin
            e = exp_q.pop_front();
            if (state !== e.st) begin
                errors++;
                $display("FAIL state vec %0d: got %0d required %0d", vec_idx, state, e.st);
            end
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL ctl vec %0d: got %b required %b", vec_idx, act, e.ctl);
            end
            checks++;
            if (instr_cnt !== e.cnt) begin
                errors++;
                $display("FAIL instr_cnt vec %0d: got %0d required %0d", vec_idx, instr_cnt, e.cnt);
            end
            checks++;
            if (trap_w !== e.trp) begin
                errors++;
                $display("FAIL trap vec %0d: got %b required %b", vec_idx, trap_w, e.trp);
            end
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst_n; enable = v.en; opcode = v.op; zero = v.zr; mem_ready = v.rdy;
        exp_q.push_back(v);
        @(negedge clk);
        check_out();
        vec_idx++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        F_WAIT  = ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
        F_RDY   = ctl(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
        F_ERR   = ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1);
        F_OFF   = ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
        DEC     = ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0);
        MADR    = ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0);
        MRD     = ctl(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        MWB     = ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        MWR     = ctl(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        MWR_OFF = ctl(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        REX     = ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0);
        AWB     = ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        BR1     = ctl(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0);
        BR0     = ctl(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0);
        JMP     = ctl(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        AIWB    = ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        TRP     = 16'h0000;

        // R-type: 0,1,6,7 then back to FETCH (first vector is the post-reset state)
        vecs.push_back(mk(1'b1, 1'b1, OP_R, 1'b0, 1'b1, 4'd0, F_RDY, 0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_R, 1'b0, 1'b1, 4'd1, DEC, 0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_R, 1'b0, 1'b1, 4'd6, REX, 0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_R, 1'b0, 1'b1, 4'd7, AWB, 0, 1'b0));
        // lw with three not-ready cycles; ready arrives on the timeout cycle
        vecs.push_back(mk(1'b1, 1'b1, OP_LW, 1'b0, 1'b1, 4'd0, F_RDY, 1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_LW, 1'b0, 1'b1, 4'd1, DEC, 1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_LW, 1'b0, 1'b1, 4'd2, MADR, 1, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b1, 1'b1, OP_LW, 1'b0, 1'b0, 4'd3, MRD, 1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_LW, 1'b0, 1'b1, 4'd3, MRD, 1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_LW, 1'b0, 1'b1, 4'd4, MWB, 1, 1'b0));
        // beq taken, then not taken
        vecs.push_back(mk(1'b1, 1'b1, OP_BQ, 1'b1, 1'b1, 4'd0, F_RDY, 2, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_BQ, 1'b1, 1'b1, 4'd1, DEC, 2, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_BQ, 1'b1, 1'b1, 4'd8, BR1, 2, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_BQ, 1'b0, 1'b1, 4'd0, F_RDY, 3, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_BQ, 1'b0, 1'b1, 4'd1, DEC, 3, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_BQ, 1'b0, 1'b1, 4'd8, BR0, 3, 1'b0));
        // fetch timeout: mem_err on the 4th and 8th waiting cycles
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++)
                vecs.push_back(mk(1'b1, 1'b1, OP_SW, 1'b0, 1'b0, 4'd0, F_WAIT, 4, 1'b0));
            vecs.push_back(mk(1'b1, 1'b1, OP_SW, 1'b0, 1'b0, 4'd0, F_ERR, 4, 1'b0));
        end
        vecs.push_back(mk(1'b1, 1'b1, OP_SW, 1'b0, 1'b1, 4'd0, F_RDY, 4, 1'b0));
        // sw frozen for five cycles in MEMWR while memory claims ready
        vecs.push_back(mk(1'b1, 1'b1, OP_SW, 1'b0, 1'b1, 4'd1, DEC, 4, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_SW, 1'b0, 1'b1, 4'd2, MADR, 4, 1'b0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b1, 1'b0, OP_SW, 1'b0, 1'b1, 4'd5, MWR_OFF, 4, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_SW, 1'b0, 1'b1, 4'd5, MWR, 4, 1'b0));
        // addi then j
        vecs.push_back(mk(1'b1, 1'b1, OP_AI, 1'b0, 1'b1, 4'd0, F_RDY, 5, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_AI, 1'b0, 1'b1, 4'd1, DEC, 5, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_AI, 1'b0, 1'b1, 4'd2, MADR, 5, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_AI, 1'b0, 1'b1, 4'd10, AIWB, 5, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_J, 1'b0, 1'b1, 4'd0, F_RDY, 6, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_J, 1'b0, 1'b1, 4'd1, DEC, 6, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_J, 1'b0, 1'b1, 4'd9, JMP, 6, 1'b0));
        // frozen in FETCH: ready ignored, strobes low
        vecs.push_back(mk(1'b1, 1'b0, OP_BAD, 1'b0, 1'b1, 4'd0, F_OFF, 7, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, OP_BAD, 1'b0, 1'b0, 4'd0, F_OFF, 7, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_BAD, 1'b0, 1'b1, 4'd0, F_RDY, 7, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, OP_BAD, 1'b0, 1'b1, 4'd1, DEC, 7, 1'b0));
`ifdef MC_CTRL_TRAP_EN
        vecs.push_back(mk(1'b1, 1'b1, OP_R, 1'b0, 1'b1, 4'd11, TRP, 7, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, OP_R, 1'b0, 1'b1, 4'd11, TRP, 7, 1'b1));
`else
        vecs.push_back(mk(1'b1, 1'b1, OP_R, 1'b0, 1'b0, 4'd0, F_WAIT, 8, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, OP_R, 1'b0, 1'b0, 4'd0, F_OFF, 8, 1'b0));
`endif
        // reset taken despite enable low
        vecs.push_back(mk(1'b1, 1'b1, OP_J, 1'b0, 1'b1, 4'd0, F_RDY, 0, 1'b0));

        rst = 1'b0; enable = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        foreach (vecs[i]) apply(vecs[i]);

        // counter wrap: seventeen jumps through a 4-bit counter
        for (int k = 0; k < 17; k++) begin
            apply(mk(1'b1, 1'b1, OP_J, 1'b0, 1'b1, 4'd1, DEC, k % 16, 1'b0));
            apply(mk(1'b1, 1'b1, OP_J, 1'b0, 1'b1, 4'd9, JMP, k % 16, 1'b0));
            apply(mk(1'b1, 1'b1, OP_J, 1'b0, 1'b1, 4'd0, F_RDY, (k + 1) % 16, 1'b0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
